// File: rtl/p2s_if.sv
// Handshake bundle between the three filter channels, the RPi CS line and
// the parallel_2_serial consumer. The timeout pulse exists only with P2S_SCHED_TIMEOUT_EN.
interface p2s_if;
  logic [15:0] ch0_data;
  logic [15:0] ch1_data;
  logic [15:0] ch2_data;
  logic [2:0]  ch_valid;
  logic        rpi_cs;
  logic        overrun_clr;
  logic [15:0] filtered_data;
  logic        filter_done;
  logic [1:0]  ch_sel;
  logic        busy;
  logic [2:0]  overrun;
`ifdef P2S_SCHED_TIMEOUT_EN
  logic        timeout;

  modport master (
    output ch0_data, ch1_data, ch2_data, ch_valid, rpi_cs, overrun_clr,
    input  filtered_data, filter_done, ch_sel, busy, overrun, timeout
  );
  modport slave (
    input  ch0_data, ch1_data, ch2_data, ch_valid, rpi_cs, overrun_clr,
    output filtered_data, filter_done, ch_sel, busy, overrun, timeout
  );
`else
  modport master (
    output ch0_data, ch1_data, ch2_data, ch_valid, rpi_cs, overrun_clr,
    input  filtered_data, filter_done, ch_sel, busy, overrun
  );
  modport slave (
    input  ch0_data, ch1_data, ch2_data, ch_valid, rpi_cs, overrun_clr,
    output filtered_data, filter_done, ch_sel, busy, overrun
  );
`endif
endinterface

// File: rtl/p2s_scheduler.sv
// Round-robin scheduler feeding three axis filter words to an RPi-clocked SPI shifter.
// Optional watchdog enabled by defining P2S_SCHED_TIMEOUT_EN.
module p2s_scheduler #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic  clk,
  input logic  rst,
  p2s_if.slave bus
);
  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {IDLE, ARMED, SHIFTING} state_e;

  state_e                       state_q, state_d;
  logic [NUM_CH-1:0]            flag_q, flag_d;
  logic [NUM_CH-1:0][15:0]      pend_q, pend_d;
  logic [NUM_CH-1:0]            overrun_q, overrun_d;
  logic [NUM_CH-1:0]            ovr_evt;
  logic [15:0]                  data_q, data_d;
  logic [1:0]                   sel_q, sel_d;
  logic [1:0]                   last_q, last_d;
  logic                         fd_q, fd_d;
  logic                         busy_q, busy_d;
  logic [SYNC_STAGES:0]         cs_pipe_q, cs_pipe_d;
  logic [SYNC_STAGES:0]         vld_pipe_q, vld_pipe_d;
  logic [NUM_CH-1:0][15:0]      ch_in;
  logic                         cs_fall, cs_rise, cs_real;
  logic                         grant;
  logic [1:0]                   gnt_idx;

  assign ch_in = {bus.ch2_data, bus.ch1_data, bus.ch0_data};

  // vld_pipe marks when every CS flop holds a real sample, so the reset-time
  // ones draining out of the chain never look like a falling edge.
  assign cs_pipe_d  = {cs_pipe_q[SYNC_STAGES-1:0], bus.rpi_cs};
  assign vld_pipe_d = {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
  assign cs_real    = vld_pipe_q[SYNC_STAGES];
  assign cs_fall    = cs_real &  cs_pipe_q[SYNC_STAGES] & ~cs_pipe_q[SYNC_STAGES-1];
  assign cs_rise    = cs_real & ~cs_pipe_q[SYNC_STAGES] &  cs_pipe_q[SYNC_STAGES-1];

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input int k);
    int c;
    c = (int'(last) + 1 + k) % NUM_CH;
    return 2'(c);
  endfunction

  always_comb begin
    gnt_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (flag_q[rr_pick(last_q, k)]) gnt_idx = rr_pick(last_q, k);
    grant = (state_q == IDLE) && (|flag_q);
  end

  // A strobe on the edge its channel is granted refills pending without overrun:
  // the old word is leaving, not being lost.
  always_comb begin
    flag_d  = flag_q;
    pend_d  = pend_q;
    ovr_evt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant && (gnt_idx == 2'(i))) flag_d[i] = 1'b0;
      if (bus.ch_valid[i]) begin
        ovr_evt[i] = flag_d[i];
        flag_d[i]  = 1'b1;
        pend_d[i]  = ch_in[i];
      end
    end
    overrun_d = (bus.overrun_clr ? '0 : overrun_q) | ovr_evt;
  end

`ifdef P2S_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  assign bus.timeout = tmo_q;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (grant) begin
        data_d  = pend_q[gnt_idx];
        sel_d   = gnt_idx;
        last_d  = gnt_idx;
        state_d = ARMED;
      end
      ARMED:    if (cs_fall) state_d = SHIFTING;
      SHIFTING: if (cs_rise) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
`ifdef P2S_SCHED_TIMEOUT_EN
    cnt_d = '0;
    tmo_d = 1'b0;
    if (state_q != IDLE) begin
      if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        tmo_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
    fd_d   = (state_d != IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flag_q     <= '0;
      pend_q     <= '0;
      overrun_q  <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      last_q     <= 2'd2;
      fd_q       <= 1'b0;
      busy_q     <= 1'b0;
      cs_pipe_q  <= '1;
      vld_pipe_q <= '0;
`ifdef P2S_SCHED_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      pend_q     <= pend_d;
      overrun_q  <= overrun_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      fd_q       <= fd_d;
      busy_q     <= busy_d;
      cs_pipe_q  <= cs_pipe_d;
      vld_pipe_q <= vld_pipe_d;
`ifdef P2S_SCHED_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bus.filtered_data = data_q;
  assign bus.filter_done   = fd_q;
  assign bus.ch_sel        = sel_q;
  assign bus.busy          = busy_q;
  assign bus.overrun       = overrun_q;
endmodule
